// File: rtl/nes_cpu_pkg.sv
// Shared CPU definitions: address width, byte type, opcode constants,
// and the opcode length / legality tables used by instruction fetch.
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;

  typedef logic [7:0] BYTE;

  // Opcodes referenced by the fetch path and its test program
  localparam BYTE BRK     = 8'h00;
  localparam BYTE ORA_IMM = 8'h09;
  localparam BYTE ORA_ABS = 8'h0D;
  localparam BYTE JMP_ABS = 8'h4C;
  localparam BYTE STA_ABS = 8'h8D;
  localparam BYTE LDA_IMM = 8'hA9;
  localparam BYTE NOP     = 8'hEA;

  // One fetched instruction. pc is sized for the widest supported bus;
  // narrower fetch units zero-extend into it.
  typedef struct packed {
    logic [MEM_ADDR_SIZE-1:0] pc;
    logic [1:0]               len;
    BYTE [2:0]                bytes;
    logic                     illegal;
  } instr_t;

  typedef logic [255:0][1:0] len_lut_t;
  typedef logic [255:0]      ill_lut_t;

  // Returns {illegal, len}. Decoded by opcode column (low nibble) since the
  // 6502 addressing mode is mostly a function of it. Undocumented -> len 1.
  function automatic logic [2:0] decode_op(input BYTE op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic       legal;
    logic [1:0] len;
    hi    = op[7:4];
    lo    = op[3:0];
    legal = 1'b0;
    len   = 2'd1;
    case (lo)
      4'h0: begin
        legal = (hi != 4'h8);
        if (hi == 4'h2)                       len = 2'd3;  // JSR abs
        else if (hi inside {4'h0, 4'h4, 4'h6}) len = 2'd1;  // BRK/RTI/RTS
        else                                  len = 2'd2;  // branches, imm
      end
      4'h1:        begin legal = 1'b1; len = 2'd2; end
      4'h2:        begin legal = (hi == 4'hA); len = 2'd2; end
      4'h4:        begin
        legal = hi inside {4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
        len   = 2'd2;
      end
      4'h5, 4'h6:  begin legal = 1'b1; len = 2'd2; end
      4'h8:        begin legal = 1'b1; len = 2'd1; end
      4'h9:        begin legal = (hi != 4'h8); len = hi[0] ? 2'd3 : 2'd2; end
      4'hA:        begin legal = !hi[0] || (hi inside {4'h9, 4'hB}); len = 2'd1; end
      4'hC:        begin
        legal = hi inside {4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE};
        len   = 2'd3;
      end
      4'hD:        begin legal = 1'b1; len = 2'd3; end
      4'hE:        begin legal = (hi != 4'h9); len = 2'd3; end
      default:     begin legal = 1'b0; len = 2'd1; end
    endcase
    if (!legal) len = 2'd1;
    return {~legal, len};
  endfunction

  function automatic len_lut_t build_len_lut();
    len_lut_t   lut;
    logic [2:0] d;
    for (int i = 0; i < 256; i++) begin
      d      = decode_op(BYTE'(i));
      lut[i] = d[1:0];
    end
    return lut;
  endfunction

  function automatic ill_lut_t build_ill_lut();
    ill_lut_t   lut;
    logic [2:0] d;
    for (int i = 0; i < 256; i++) begin
      d      = decode_op(BYTE'(i));
      lut[i] = d[2];
    end
    return lut;
  endfunction

  localparam len_lut_t instr_len_lut     = build_len_lut();
  localparam ill_lut_t instr_illegal_lut = build_ill_lut();

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO. Entry 0 is always the head; the occupancy
// state doubles as the queue's control FSM.
module fetch_queue
  import nes_cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  instr_t     i_data,
  output instr_t     o_head,
  output logic       o_valid,
  output logic [1:0] o_count
);

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  q_state_e r_state;
  q_state_e w_next;
  instr_t   r_e0;
  instr_t   r_e1;

  // Occupancy state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= Q_EMPTY;
    else       r_state <= w_next;
  end

  // Occupancy transitions; flush dominates push and pop
  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = Q_EMPTY;
    end else begin
      case (r_state)
        Q_EMPTY: if (i_push)            w_next = Q_ONE;
        Q_ONE: begin
          if (i_push && !i_pop)         w_next = Q_FULL;
          else if (i_pop && !i_push)    w_next = Q_EMPTY;
        end
        Q_FULL:  if (i_pop && !i_push)  w_next = Q_ONE;
        default:                        w_next = Q_EMPTY;
      endcase
    end
  end

  // Status outputs decoded from the occupancy state
  always_comb begin
    o_count = r_state;
    o_valid = (r_state != Q_EMPTY);
    o_head  = r_e0;
  end

  // Entry storage: pops shift entry 1 forward, pushes land in the first
  // free slot as seen after the pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (!i_flush) begin
      if (i_pop && i_push) begin
        if (r_state == Q_FULL) begin
          r_e0 <= r_e1;
          r_e1 <= i_data;
        end else begin
          r_e0 <= i_data;
        end
      end else if (i_pop) begin
        r_e0 <= r_e1;
      end else if (i_push) begin
        if (r_state == Q_EMPTY) r_e0 <= i_data;
        else                    r_e1 <= i_data;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads a 3-byte window at PC, decodes length, trims
// unused bytes, advances PC and queues the instruction for the decoder.
module fetch_unit
  import nes_cpu_pkg::*;
#(
  parameter int                ADDR_W   = MEM_ADDR_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [23:0]       mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [23:0]       instr_o,
  output logic [1:0]        instr_len_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_illegal_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        w_len;
  logic              w_illegal;
  logic [23:0]       w_bytes;
  instr_t            w_entry;
  instr_t            w_head;
  logic              w_q_valid;
  logic [1:0]        w_count;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;

  assign w_len     = instr_len_lut[mem_data_i[7:0]];
  assign w_illegal = instr_illegal_lut[mem_data_i[7:0]];

  // Zero the operand bytes the opcode does not use
  always_comb begin
    w_bytes = mem_data_i;
    case (w_len)
      2'd1:    w_bytes = {16'h0000, mem_data_i[7:0]};
      2'd2:    w_bytes = {8'h00, mem_data_i[15:0]};
      default: w_bytes = mem_data_i;
    endcase
  end

  always_comb begin
    w_entry.pc      = MEM_ADDR_SIZE'(r_pc);
    w_entry.len     = w_len;
    w_entry.bytes   = w_bytes;
    w_entry.illegal = w_illegal;
  end

  // Outputs are forced idle during reset so nothing leaks before the
  // reset edge takes effect.
  assign w_valid = w_q_valid && !rst_i;
  assign w_pop   = w_valid && instr_ready_i;
  assign w_push  = ((w_count != 2'd2) || w_pop) && !redirect_i;

  // PC: reset beats redirect, redirect beats sequential advance
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_pc <= RESET_PC;
    else if (redirect_i) r_pc <= redirect_pc_i;
    else if (w_push)     r_pc <= r_pc + ADDR_W'(w_len);
  end

  fetch_queue u_queue (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_valid (w_q_valid),
    .o_count (w_count)
  );

  assign mem_addr_o      = rst_i ? RESET_PC : r_pc;
  assign instr_valid_o   = w_valid;
  assign instr_o         = w_valid ? w_head.bytes : 24'h0;
  assign instr_len_o     = w_valid ? w_head.len : 2'd0;
  assign instr_pc_o      = w_valid ? ADDR_W'(w_head.pc) : '0;
  assign instr_illegal_o = w_valid && w_head.illegal;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model plus hand-computed heads.
module tb_fetch_unit;
  import nes_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic [23:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        instr_illegal;
  logic        redirect;
  logic [15:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  BYTE mem [65536];

  // head tuple: {valid, pc, len, bytes, illegal}
  logic [43:0] head;
  assign head = {instr_valid, instr_pc, instr_len, instr, instr_illegal};

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mem_addr_o      (mem_addr),
    .mem_data_i      (mem_data),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .instr_o         (instr),
    .instr_len_o     (instr_len),
    .instr_pc_o      (instr_pc),
    .instr_illegal_o (instr_illegal),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a1, a2;
  always_comb begin
    a1       = mem_addr + 16'd1;
    a2       = mem_addr + 16'd2;
    mem_data = {mem[a2], mem[a1], mem[mem_addr]};
  end

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (head !== 44'h0) begin n_err++; $display("FAIL reset_head: got %h want %h", head, 44'h0); end
    n_vec++;
    if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h want %h", mem_addr, 16'h0); end
  endtask

  task automatic test_stream();
    logic [43:0] exp [3];
    logic [15:0] ea  [3];
    exp[0] = {1'b1, 16'h0000, 2'd2, 24'h00AA09, 1'b0}; ea[0] = 16'h0002;
    exp[1] = {1'b1, 16'h0002, 2'd3, 24'h12340D, 1'b0}; ea[1] = 16'h0005;
    exp[2] = {1'b1, 16'h0005, 2'd1, 24'h0000EA, 1'b0}; ea[2] = 16'h0006;
    rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (head !== exp[i]) begin n_err++; $display("FAIL stream_head%0d: got %h want %h", i, head, exp[i]); end
      n_vec++;
      if (mem_addr !== ea[i]) begin n_err++; $display("FAIL stream_addr%0d: got %h want %h", i, mem_addr, ea[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [43:0] exp [3];
    logic [15:0] ea  [3];
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (head !== {1'b1, 16'h0005, 2'd1, 24'h0000EA, 1'b0}) begin
        n_err++; $display("FAIL stall_head%0d: got %h want pc 0005 EA", i, head);
      end
      n_vec++;
      if (mem_addr !== 16'h0008) begin n_err++; $display("FAIL stall_addr%0d: got %h want 0008", i, mem_addr); end
    end
    exp[0] = {1'b1, 16'h0006, 2'd2, 24'h0001A9, 1'b0}; ea[0] = 16'h000B;
    exp[1] = {1'b1, 16'h0008, 2'd3, 24'h02008D, 1'b0}; ea[1] = 16'h000C;
    exp[2] = {1'b1, 16'h000B, 2'd1, 24'h0000EA, 1'b0}; ea[2] = 16'h000D;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (head !== exp[i]) begin n_err++; $display("FAIL drain_head%0d: got %h want %h", i, head, exp[i]); end
      n_vec++;
      if (mem_addr !== ea[i]) begin n_err++; $display("FAIL drain_addr%0d: got %h want %h", i, mem_addr, ea[i]); end
    end
  endtask

  task automatic test_redirect();
    // queue already holds B and C; stall one cycle to confirm it is full
    instr_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_addr !== 16'h000D) begin n_err++; $display("FAIL full_hold_addr: got %h want 000D", mem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0040; instr_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    n_vec++;
    if (head !== 44'h0) begin n_err++; $display("FAIL redir_flush: got %h want %h", head, 44'h0); end
    n_vec++;
    if (mem_addr !== 16'h0040) begin n_err++; $display("FAIL redir_addr: got %h want 0040", mem_addr); end
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'h0040, 2'd3, 24'h10004C, 1'b0}) begin
      n_err++; $display("FAIL redir_head: got %h want pc 0040 len 3 10004C", head);
    end
    n_vec++;
    if (mem_addr !== 16'h0043) begin n_err++; $display("FAIL redir_next_addr: got %h want 0043", mem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    n_vec++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_setup: got valid %b addr %h want 0 FFFF", instr_valid, mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'hFFFF, 2'd1, 24'h0000EA, 1'b0}) begin
      n_err++; $display("FAIL wrap_head: got %h want pc FFFF len 1 EA", head);
    end
    n_vec++;
    if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr: got %h want 0000", mem_addr); end
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'h0000, 2'd2, 24'h00AA09, 1'b0}) begin
      n_err++; $display("FAIL wrap_next_head: got %h want pc 0000 len 2 00AA09", head);
    end
  endtask

  task automatic test_illegal_reset();
    redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'h0080, 2'd1, 24'h000002, 1'b1}) begin
      n_err++; $display("FAIL illegal_head: got %h want pc 0080 len 1 000002 ill 1", head);
    end
    n_vec++;
    if (mem_addr !== 16'h0081) begin n_err++; $display("FAIL illegal_addr: got %h want 0081", mem_addr); end
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'h0081, 2'd1, 24'h0000EA, 1'b0}) begin
      n_err++; $display("FAIL post_illegal_head: got %h want pc 0081 EA", head);
    end
    // reset mid-stream together with a redirect: reset must win
    rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    n_vec++;
    if (head !== 44'h0) begin n_err++; $display("FAIL midrst_head: got %h want %h", head, 44'h0); end
    rst = 1'b0; redirect = 1'b0;
    n_vec++;
    if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL midrst_addr: got %h want 0000", mem_addr); end
    @(negedge clk);
    n_vec++;
    if (head !== {1'b1, 16'h0000, 2'd2, 24'h00AA09, 1'b0}) begin
      n_err++; $display("FAIL restart_head: got %h want pc 0000 len 2 00AA09", head);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = NOP;
    mem[16'h0000] = ORA_IMM; mem[16'h0001] = 8'hAA;
    mem[16'h0002] = ORA_ABS; mem[16'h0003] = 8'h34; mem[16'h0004] = 8'h12;
    mem[16'h0005] = NOP;
    mem[16'h0006] = LDA_IMM; mem[16'h0007] = 8'h01;
    mem[16'h0008] = STA_ABS; mem[16'h0009] = 8'h00; mem[16'h000A] = 8'h02;
    mem[16'h0040] = JMP_ABS; mem[16'h0041] = 8'h00; mem[16'h0042] = 8'h10;
    mem[16'h0080] = 8'h02;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_illegal_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
